// File: rtl/branch_predict_ctrl_pkg.sv
// branch_predict_ctrl_pkg: shared encodings, constants and index helpers for the branch predictor
package branch_predict_ctrl_pkg;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam int PC_ALIGN = 2;
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction
endpackage

// File: rtl/branch_predict_ctrl_sat_counter2.sv
// sat_counter2: next value of a 2-bit saturating counter, with a force-to-strongly-taken override
module sat_counter2
  import branch_predict_ctrl_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_inc,
  input  logic       i_force,
  output logic [1:0] o_cnt
);
  assign o_cnt = i_force ? ST
               : i_inc   ? ((i_cnt == ST)  ? ST  : i_cnt + 2'd1)
               :           ((i_cnt == SNT) ? SNT : i_cnt - 2'd1);
endmodule

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: BHT/BTB next-PC prediction, EX mispredict redirect/flush, training and perf counters
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] ifPc,
  output logic        predTaken,
  output logic [31:0] predTarget,
  input  logic        exValid,
  input  logic        exStall,
  input  logic        exIsCtrl,
  input  logic        exIsJump,
  input  logic [31:0] exPc,
  input  logic [31:0] exTarget,
  input  logic        exTaken,
  input  logic        exPredTaken,
  input  logic [31:0] exPredTarget,
  output logic        redirect,
  output logic [31:0] redirectPc,
  output logic        flush,
  output logic [31:0] branchCount,
  output logic [31:0] mispredCount
);
  localparam int IDX = idx_w(ENTRIES);
  localparam int TLO = PC_ALIGN + IDX;

  logic [1:0]       r_bht     [ENTRIES];
  logic [ENTRIES-1:0] r_btb_v;
  logic [TAG_W-1:0] r_btb_tag [ENTRIES];
  logic [31:0]      r_btb_tgt [ENTRIES];
  logic [31:0]      r_branch_cnt;
  logic [31:0]      r_mis_cnt;

  logic [IDX-1:0]   w_if_idx;
  logic [IDX-1:0]   w_ex_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_hit;
  logic             w_res;
  logic             w_mis;
  logic [1:0]       w_bht_next;
  logic             w_unused;

  assign w_if_idx = ifPc[TLO-1:PC_ALIGN];
  assign w_ex_idx = exPc[TLO-1:PC_ALIGN];
  assign w_if_tag = ifPc[TLO+TAG_W-1:TLO];
  assign w_ex_tag = exPc[TLO+TAG_W-1:TLO];
  assign w_unused = ^{ifPc, exPc};

  // Lookup reads pre-update state; a tag miss always predicts fall-through
  assign w_hit      = r_btb_v[w_if_idx] && (r_btb_tag[w_if_idx] == w_if_tag);
  assign predTaken  = w_hit && r_bht[w_if_idx][1];
  assign predTarget = predTaken ? r_btb_tgt[w_if_idx] : ifPc + INSTR_BYTES;

  assign w_res      = exValid && exIsCtrl && !exStall;
  assign w_mis      = w_res && ((exTaken != exPredTaken) ||
                                (exTaken && exPredTaken && (exTarget != exPredTarget)));
  assign redirect   = w_mis;
  assign flush      = w_mis;
  assign redirectPc = exTaken ? exTarget : exPc + INSTR_BYTES;

  assign branchCount  = r_branch_cnt;
  assign mispredCount = r_mis_cnt;

  sat_counter2 u_sat (
    .i_cnt   (r_bht[w_ex_idx]),
    .i_inc   (exTaken),
    .i_force (exIsJump),
    .o_cnt   (w_bht_next)
  );

  // BHT counters and BTB valid bits train on every resolved control instruction
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= WNT;
      r_btb_v <= '0;
    end else if (w_res) begin
      r_bht[w_ex_idx] <= w_bht_next;
      if (exTaken) r_btb_v[w_ex_idx] <= 1'b1;
    end
  end

  // BTB tag/target payload is qualified by the valid bit, so it needs no reset
  always_ff @(posedge clk) begin
    if (w_res && exTaken) begin
      r_btb_tag[w_ex_idx] <= w_ex_tag;
      r_btb_tgt[w_ex_idx] <= exTarget;
    end
  end

  // Performance counters, wrapping naturally at 2^32
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_branch_cnt <= '0;
      r_mis_cnt    <= '0;
    end else begin
      r_branch_cnt <= r_branch_cnt + {31'd0, w_res};
      r_mis_cnt    <= r_mis_cnt + {31'd0, w_mis};
    end
  end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed self-checking bench for branch_predict_ctrl
module tb_branch_predict_ctrl;
  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [31:0] ifPc = 32'h100;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        exValid = 1'b0, exStall = 1'b0, exIsCtrl = 1'b0, exIsJump = 1'b0;
  logic [31:0] exPc = '0, exTarget = '0, exPredTarget = '0;
  logic        exTaken = 1'b0, exPredTaken = 1'b0;
  logic        redirect, flush;
  logic [31:0] redirectPc, branchCount, mispredCount;
  int total = 0;
  int bad = 0;

  branch_predict_ctrl dut (
    .clk(clk), .resetN(resetN), .ifPc(ifPc), .predTaken(predTaken), .predTarget(predTarget),
    .exValid(exValid), .exStall(exStall), .exIsCtrl(exIsCtrl), .exIsJump(exIsJump),
    .exPc(exPc), .exTarget(exTarget), .exTaken(exTaken), .exPredTaken(exPredTaken),
    .exPredTarget(exPredTarget), .redirect(redirect), .redirectPc(redirectPc), .flush(flush),
    .branchCount(branchCount), .mispredCount(mispredCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_drive(input logic [31:0] pc, input logic jmp, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    exValid = 1'b1; exIsCtrl = 1'b1; exStall = 1'b0; exIsJump = jmp;
    exPc = pc; exTaken = tk; exTarget = tgt; exPredTaken = ptk; exPredTarget = ptgt;
    #1;
  endtask

  task automatic ex_clear();
    exValid = 1'b0; exIsCtrl = 1'b0; exStall = 1'b0; exIsJump = 1'b0;
    exTaken = 1'b0; exPredTaken = 1'b0;
    #1;
  endtask

  task automatic pred(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    ifPc = pc;
    #1;
    chk({tag, "_tk"}, {31'd0, predTaken}, {31'd0, tk});
    chk({tag, "_tgt"}, predTarget, tgt);
  endtask

  task automatic counts(input string tag, input int b, input int m);
    chk({tag, "_bcnt"}, branchCount, b);
    chk({tag, "_mcnt"}, mispredCount, m);
  endtask

  task automatic redir(input string tag, input logic r, input logic [31:0] pc);
    chk({tag, "_redir"}, {31'd0, redirect}, {31'd0, r});
    chk({tag, "_flush"}, {31'd0, flush}, {31'd0, r});
    if (r) chk({tag, "_rpc"}, redirectPc, pc);
  endtask

  initial begin
    step(); step();
    resetN = 1'b1;
    #1;
    pred("rst", 32'h100, 1'b0, 32'h104);
    redir("rst", 1'b0, 32'h0);
    counts("rst", 0, 0);

    ex_drive(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    redir("beq_tk", 1'b1, 32'h80);
    pred("beq_nobypass", 32'h100, 1'b0, 32'h104);
    step(); ex_clear();
    pred("beq_trained", 32'h100, 1'b1, 32'h80);
    counts("beq_trained", 1, 1);

    ex_drive(32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    redir("beq_nt1", 1'b1, 32'h104);
    step(); ex_clear();
    pred("beq_nt1", 32'h100, 1'b0, 32'h104);
    counts("beq_nt1", 2, 2);

    ex_drive(32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
    redir("beq_nt2", 1'b0, 32'h0);
    step();
    redir("beq_nt3", 1'b0, 32'h0);
    step(); ex_clear();
    counts("beq_nt3", 4, 2);

    ex_drive(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    redir("beq_sat", 1'b1, 32'h80);
    step(); ex_clear();
    pred("beq_sat", 32'h100, 1'b0, 32'h104);
    counts("beq_sat", 5, 3);

    ex_drive(32'h200, 1'b1, 1'b1, 32'h300, 1'b0, 32'h204);
    redir("jalr1", 1'b1, 32'h300);
    step(); ex_clear();
    pred("jalr1", 32'h200, 1'b1, 32'h300);
    ex_drive(32'h200, 1'b1, 1'b1, 32'h340, 1'b1, 32'h300);
    redir("jalr2", 1'b1, 32'h340);
    step(); ex_clear();
    pred("jalr2", 32'h200, 1'b1, 32'h340);
    ex_drive(32'h200, 1'b1, 1'b1, 32'h340, 1'b1, 32'h340);
    redir("jalr3", 1'b0, 32'h0);
    step(); ex_clear();
    counts("jalr3", 8, 5);

    ex_drive(32'h400, 1'b0, 1'b1, 32'h500, 1'b0, 32'h404);
    exStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      redir("stall", 1'b0, 32'h0);
      step();
    end
    counts("stall", 8, 5);
    pred("stall", 32'h400, 1'b0, 32'h404);
    exStall = 1'b0;
    #1;
    redir("release", 1'b1, 32'h500);
    step(); ex_clear();
    counts("release", 9, 6);

    ex_drive(32'h600, 1'b0, 1'b1, 32'h700, 1'b0, 32'h604);
    exValid = 1'b0;
    #1;
    redir("novalid", 1'b0, 32'h0);
    exValid = 1'b1; exIsCtrl = 1'b0;
    #1;
    redir("noctrl", 1'b0, 32'h0);
    step(); ex_clear();
    counts("noeffect", 9, 6);
    pred("noeffect", 32'h600, 1'b0, 32'h604);

    ex_drive(32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    redir("alias_train", 1'b0, 32'h0);
    step(); ex_clear();
    pred("alias_same", 32'h4100, 1'b1, 32'h80);
    pred("alias_diff", 32'h140, 1'b0, 32'h144);
    counts("alias", 10, 6);

    ex_drive(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h10, 1'b1, 32'h10);
    redir("wrap", 1'b1, 32'h0);
    ex_clear();
    pred("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    resetN = 1'b0;
    #1;
    counts("midrst", 0, 0);
    pred("midrst", 32'h100, 1'b0, 32'h104);
    step();
    resetN = 1'b1;
    #1;
    pred("postrst", 32'h200, 1'b0, 32'h204);
    counts("postrst", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
